// File: rtl/hbm_reset_seq_if.sv
// Reset-sequencer handshake bundle: request/calibration inputs and the
// sequenced reset, status and state outputs.
interface hbm_reset_seq_if;
  logic       req_rstn;
  logic       cal_done;
  logic       hbm_rstn;
  logic       user_rstn;
  logic       cal_fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  modport master (
    output req_rstn,
    output cal_done,
    input  hbm_rstn,
    input  user_rstn,
    input  cal_fail,
    input  retry_cnt,
    input  state
  );

  modport slave (
    input  req_rstn,
    input  cal_done,
    output hbm_rstn,
    output user_rstn,
    output cal_fail,
    output retry_cnt,
    output state
  );
endinterface

// File: rtl/hbm_reset_seq.sv
// HBM reset sequencer: holds HBM in reset, waits for calibration with timeout
// and bounded retry, and releases user reset only after calibration settles.
module hbm_reset_seq #(
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned CAL_TIMEOUT   = 1048576,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 24
) (
  input  logic            clk,
  input  logic            rst,
  hbm_reset_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ASSERT   = 3'd1,
    S_WAIT_CAL = 3'd2,
    S_SETTLE   = 3'd3,
    S_RUN      = 3'd4,
    S_FAIL     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMER_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [3:0]       RETRY_C   = 4'(MAX_RETRY);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] timer_q,  timer_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [3:0]       retry_q,  retry_d;
  logic             hbm_q,    hbm_d;
  logic             user_q,   user_d;
  logic             fail_q,   fail_d;
  logic             sync1_q,  sync2_q;

  logic             cal_sync;
  logic             timeout;
  logic             expire;
  logic [CNT_W-1:0] timer_inc;

  assign cal_sync  = sync2_q;
  // Timer saturates so a late timeout check can never be skipped by wrap-around.
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + ONE_C;
  assign timeout   = (timer_q >= TMO_C);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    settle_d = settle_q;
    retry_d  = retry_q;
    hbm_d    = hbm_q;
    user_d   = user_q;
    fail_d   = fail_q;
    expire   = 1'b0;

    if (!bus.req_rstn) begin
      state_d  = S_IDLE;
      timer_d  = '0;
      settle_d = '0;
      retry_d  = '0;
      fail_d   = 1'b0;
      hbm_d    = 1'b0;
      user_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hbm_d   = 1'b0;
          user_d  = 1'b0;
          state_d = S_ASSERT;
          timer_d = '0;
        end
        S_ASSERT: begin
          hbm_d  = 1'b0;
          user_d = 1'b0;
          if (timer_q >= HOLD_C) begin
            state_d = S_WAIT_CAL;
            timer_d = '0;
            hbm_d   = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_WAIT_CAL: begin
          timer_d = timer_inc;
          // A calibration edge seen on the timeout cycle still counts.
          if (cal_sync) begin
            state_d  = S_SETTLE;
            settle_d = '0;
          end else if (timeout) begin
            expire = 1'b1;
          end
        end
        S_SETTLE: begin
          timer_d = timer_inc;
          if (cal_sync && (settle_q >= SETTLE_C)) begin
            state_d = S_RUN;
            user_d  = 1'b1;
          end else if (timeout) begin
            expire = 1'b1;
          end else if (!cal_sync) begin
            state_d  = S_WAIT_CAL;
            settle_d = '0;
          end else begin
            settle_d = settle_q + ONE_C;
          end
        end
        S_RUN: begin
          if (!cal_sync) begin
            state_d  = S_ASSERT;
            timer_d  = '0;
            settle_d = '0;
            retry_d  = '0;
            hbm_d    = 1'b0;
            user_d   = 1'b0;
          end
        end
        S_FAIL: begin
          hbm_d  = 1'b0;
          user_d = 1'b0;
          fail_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          hbm_d   = 1'b0;
          user_d  = 1'b0;
        end
      endcase

      // Attempt expired: retry from a fresh HBM reset or give up for good.
      if (expire) begin
        hbm_d    = 1'b0;
        user_d   = 1'b0;
        settle_d = '0;
        if (retry_q < RETRY_C) begin
          retry_d = retry_q + 4'd1;
          state_d = S_ASSERT;
          timer_d = '0;
        end else begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      settle_q <= '0;
      retry_q  <= '0;
      hbm_q    <= 1'b0;
      user_q   <= 1'b0;
      fail_q   <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      settle_q <= settle_d;
      retry_q  <= retry_d;
      hbm_q    <= hbm_d;
      user_q   <= user_d;
      fail_q   <= fail_d;
      sync1_q  <= bus.cal_done;
      sync2_q  <= sync1_q;
    end
  end

  assign bus.hbm_rstn  = hbm_q;
  assign bus.user_rstn = user_q;
  assign bus.cal_fail  = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule
